// File: rtl/pc_pkg.sv
// Shared next-PC mode encodings, imported by decode and the PC unit.
//   pcsel_t        : 3-bit next-PC select code
//   PCSEL_*        : mode encodings (110/111 are reserved)
//   pcsel_reserved : true for the reserved encodings
package pc_pkg;

  typedef logic [2:0] pcsel_t;

  localparam pcsel_t PCSEL_NORMAL = 3'b000;
  localparam pcsel_t PCSEL_BEQ    = 3'b001;
  localparam pcsel_t PCSEL_JMP    = 3'b010;
  localparam pcsel_t PCSEL_BNE    = 3'b011;
  localparam pcsel_t PCSEL_CALL   = 3'b100;
  localparam pcsel_t PCSEL_RET    = 3'b101;

  function automatic logic pcsel_reserved(input pcsel_t sel);
    return sel[2] & sel[1];
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry, so the newest DEPTH addresses are always retained.
//   clk, rst  : clock, synchronous active-high reset (empties the stack)
//   push      : write push_data as the new top
//   pop       : discard the top entry (ignored when empty)
//   push_data : address to push
//   top_data  : current top entry (undefined when empty)
//   count     : number of valid entries, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;

  // Pointer/count update; wr_ptr always names the slot the next push fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && (count != '0)) begin
      wr_ptr <= wr_ptr - PTR_W'(1);
      count  <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries beyond count are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign top_data = mem[wr_ptr - PTR_W'(1)];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit with signed branches, CALL/RET through a return
// stack, and sticky error flags.
//   clk, rst      : clock, synchronous active-high reset
//   clk_en        : advance enable (0 = stall, all state holds)
//   pcsel         : next-PC mode (see pc_pkg)
//   offset        : signed branch displacement in words
//   address       : JMP/CALL target, BEQ/BNE compare operand
//   clr_err       : clear sticky flags (honoured even when stalled)
//   pc_out        : current PC
//   ras_count     : valid return-stack entries
//   err_overflow  : CALL seen with stack full
//   err_underflow : RET seen with stack empty
//   err_illegal   : reserved pcsel seen while enabled
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          OFF_WIDTH    = 16,
  parameter int unsigned          RAS_DEPTH    = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  localparam int unsigned         CNT_W        = $clog2(RAS_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  pcsel_t               pcsel,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]  address,
  input  logic                 clr_err,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic [CNT_W-1:0]     ras_count,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_illegal
);

  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] seq;
  logic [PC_WIDTH-1:0] br;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_push;
  logic                ras_pop;
  logic                ras_full;
  logic                ras_empty;
  logic                set_ovf;
  logic                set_unf;
  logic                set_ill;

  assign off_ext = PC_WIDTH'($signed(offset));
  assign seq     = pc_out + PC_WIDTH'(1);
  assign br      = seq + off_ext;

  // Next-PC select; stack side effects only fire when the unit advances.
  always_comb begin
    next_pc  = seq;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_ill  = 1'b0;
    case (pcsel)
      PCSEL_NORMAL: ;
      PCSEL_BEQ:  if (address == '0) next_pc = br;
      PCSEL_BNE:  if (address != '0) next_pc = br;
      PCSEL_JMP:  next_pc = address;
      PCSEL_CALL: begin
        next_pc  = address;
        ras_push = clk_en;
        set_ovf  = ras_full;
      end
      PCSEL_RET: begin
        if (!ras_empty) begin
          next_pc = ras_top;
          ras_pop = clk_en;
        end else begin
          set_unf = 1'b1;
        end
      end
      default: set_ill = pcsel_reserved(pcsel);
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= RESET_VECTOR;
    end else if (clk_en) begin
      pc_out <= next_pc;
    end
  end

  // Sticky flags: a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      if (clr_err) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
        err_illegal   <= 1'b0;
      end
      if (clk_en) begin
        if (set_ovf) err_overflow  <= 1'b1;
        if (set_unf) err_underflow <= 1'b1;
        if (set_ill) err_illegal   <= 1'b1;
      end
    end
  end

  ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras (RAS_DEPTH = 4, RESET_VECTOR = 0x100).
module tb_pc_unit_ras;
  import pc_pkg::*;

  localparam int unsigned PW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  pcsel_t        pcsel;
  logic [OW-1:0] offset;
  logic [PW-1:0] address;
  logic          clr_err;
  logic [PW-1:0] pc_out;
  logic [CW-1:0] ras_count;
  logic          err_overflow;
  logic          err_underflow;
  logic          err_illegal;

  typedef struct {
    string         tag;
    logic [PW-1:0] pc;
    logic [CW-1:0] cnt;
    logic [2:0]    flags;  // {overflow, underflow, illegal}
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  pc_unit_ras #(
    .PC_WIDTH     (PW),
    .OFF_WIDTH    (OW),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (32'h100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .pcsel         (pcsel),
    .offset        (offset),
    .address       (address),
    .clr_err       (clr_err),
    .pc_out        (pc_out),
    .ras_count     (ras_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_illegal   (err_illegal)
  );

  always #5 clk = ~clk;

  // Drive one cycle, queue its expected outcome, clock, then pop and compare.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic clr, input pcsel_t sel, input logic [OW-1:0] off,
                      input logic [PW-1:0] addr, input logic [PW-1:0] e_pc,
                      input logic [CW-1:0] e_cnt, input logic [2:0] e_flags);
    exp_t e;
    logic [2:0] flags;
    rst = r; clk_en = en; clr_err = clr; pcsel = sel; offset = off; address = addr;
    q.push_back('{tag, e_pc, e_cnt, e_flags});
    @(posedge clk);
    #1;
    total++;
    assert (q.size() == 1) passed++;
    else $error("FAIL %s scoreboard depth got %0d exp 1", tag, q.size());
    if (q.size() == 0) return;
    e = q.pop_front();
    flags = {err_overflow, err_underflow, err_illegal};
    total++;
    assert (pc_out === e.pc) passed++;
    else $error("FAIL %s pc_out got %h exp %h", e.tag, pc_out, e.pc);
    total++;
    assert (ras_count === e.cnt) passed++;
    else $error("FAIL %s ras_count got %0d exp %0d", e.tag, ras_count, e.cnt);
    total++;
    assert (flags === e.flags) passed++;
    else $error("FAIL %s flags(ovf,unf,ill) got %b exp %b", e.tag, flags, e.flags);
  endtask

  initial begin
    // Reset beats a jump held during reset.
    step("rst_jmp0", 1, 1, 0, PCSEL_JMP, 16'h0, 32'h55, 32'h100, 0, 3'b000);
    step("rst_jmp1", 1, 1, 0, PCSEL_JMP, 16'h0, 32'h55, 32'h100, 0, 3'b000);

    // Sequential advance, then stall.
    step("norm1", 0, 1, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h101, 0, 3'b000);
    step("norm2", 0, 1, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h102, 0, 3'b000);
    step("norm3", 0, 1, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h103, 0, 3'b000);
    step("stall1", 0, 0, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h103, 0, 3'b000);
    step("stall2", 0, 0, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h103, 0, 3'b000);
    step("stall_call", 0, 0, 0, PCSEL_CALL, 16'h0, 32'h999, 32'h103, 0, 3'b000);
    step("stall_rsv", 0, 0, 0, 3'b110, 16'h0, 32'h0, 32'h103, 0, 3'b000);

    // Branches with signed offsets and wrap-around.
    step("jmp20", 0, 1, 0, PCSEL_JMP, 16'h0, 32'h20, 32'h20, 0, 3'b000);
    step("beq_tk", 0, 1, 0, PCSEL_BEQ, 16'hFFFC, 32'h0, 32'h1D, 0, 3'b000);
    step("bne_nt", 0, 1, 0, PCSEL_BNE, 16'hFFFC, 32'h0, 32'h1E, 0, 3'b000);
    step("bne_tk", 0, 1, 0, PCSEL_BNE, 16'hFFFC, 32'h5, 32'h1B, 0, 3'b000);
    step("beq_nt", 0, 1, 0, PCSEL_BEQ, 16'hFFFC, 32'h5, 32'h1C, 0, 3'b000);
    step("jmp_max", 0, 1, 0, PCSEL_JMP, 16'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'b000);
    step("beq_wrap", 0, 1, 0, PCSEL_BEQ, 16'h0, 32'h0, 32'h0, 0, 3'b000);
    step("beq_pos", 0, 1, 0, PCSEL_BEQ, 16'h10, 32'h0, 32'h11, 0, 3'b000);

    // Nested call/return.
    step("jmp10", 0, 1, 0, PCSEL_JMP, 16'h0, 32'h10, 32'h10, 0, 3'b000);
    step("call400", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h400, 32'h400, 1, 3'b000);
    step("norm401", 0, 1, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'h401, 1, 3'b000);
    step("call800", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h800, 32'h800, 2, 3'b000);
    step("ret402", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h402, 1, 3'b000);
    step("ret11", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h11, 0, 3'b000);

    // Overflow: five calls into a 4-deep stack keep the newest four.
    step("jmp10b", 0, 1, 0, PCSEL_JMP, 16'h0, 32'h10, 32'h10, 0, 3'b000);
    step("callA", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h20, 32'h20, 1, 3'b000);
    step("callB", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h30, 32'h30, 2, 3'b000);
    step("callC", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h40, 32'h40, 3, 3'b000);
    step("callD", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h50, 32'h50, 4, 3'b000);
    step("callE_ovf", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h60, 32'h60, 4, 3'b100);
    step("ret51", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h51, 3, 3'b100);
    step("ret41", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h41, 2, 3'b100);
    step("ret31", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h31, 1, 3'b100);
    step("ret21", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h21, 0, 3'b100);

    // Underflow, illegal, clearing and clear-vs-set priority.
    step("clr_ovf", 0, 1, 1, PCSEL_NORMAL, 16'h0, 32'h0, 32'h22, 0, 3'b000);
    step("jmp7", 0, 1, 0, PCSEL_JMP, 16'h0, 32'h7, 32'h7, 0, 3'b000);
    step("ret_unf", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h8, 0, 3'b010);
    step("rsv110", 0, 1, 0, 3'b110, 16'h0, 32'h0, 32'h9, 0, 3'b011);
    step("clr_stall", 0, 0, 1, PCSEL_NORMAL, 16'h0, 32'h0, 32'h9, 0, 3'b000);
    step("clr_vs_unf", 0, 1, 1, PCSEL_RET, 16'h0, 32'h0, 32'hA, 0, 3'b010);
    step("sticky", 0, 1, 0, PCSEL_NORMAL, 16'h0, 32'h0, 32'hB, 0, 3'b010);
    step("rsv111", 0, 1, 0, 3'b111, 16'h0, 32'h0, 32'hC, 0, 3'b011);

    // Reset in the middle of a call chain empties the stack.
    step("call200", 0, 1, 0, PCSEL_CALL, 16'h0, 32'h200, 32'h200, 1, 3'b011);
    step("rst_mid", 1, 1, 0, PCSEL_CALL, 16'h0, 32'h300, 32'h100, 0, 3'b000);
    step("ret_post", 0, 1, 0, PCSEL_RET, 16'h0, 32'h0, 32'h101, 0, 3'b010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
